// File: rtl/mic_level_meter.sv
`default_nettype none
// ============================================================================
// Module      : mic_level_meter
// Description : Windowed peak detector for a 12-bit offset-binary microphone
//               stream, driving a 4-bit bar-graph level with one-step decay.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_level_meter #(
   parameter int WINDOW = 2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [11:0] sample,
   output logic [3:0]  level,
   output logic        level_valid,
   output logic [10:0] peak
);

   localparam logic [15:0] c_last = 16'(WINDOW - 1);

   logic [10:0] r_mag;
   logic        r_mag_v;
   logic [10:0] r_acc;
   logic [15:0] r_win_cnt;
   logic [3:0]  r_level;
   logic        r_level_valid;
   logic [10:0] r_peak;

   logic [10:0] w_mag;
   logic [10:0] w_final;
   logic        w_close;
   logic [3:0]  w_new_level;

   // Upper half maps to sample-2048, lower half to 2047-sample (bit inversion).
   assign w_mag       = sample[11] ? sample[10:0] : ~sample[10:0];
   assign w_final     = (r_mag > r_acc) ? r_mag : r_acc;
   assign w_close     = r_mag_v && (r_win_cnt == c_last);
   assign w_new_level = w_final[10:7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mag         <= '0;
         r_mag_v       <= 1'b0;
         r_acc         <= '0;
         r_win_cnt     <= '0;
         r_level       <= '0;
         r_level_valid <= 1'b0;
         r_peak        <= '0;
      end else begin
         r_mag_v       <= sample_valid;
         r_level_valid <= 1'b0;
         if (sample_valid) begin
            r_mag <= w_mag;
         end
         if (r_mag_v) begin
            if (w_close) begin
               r_acc         <= '0;
               r_win_cnt     <= '0;
               r_peak        <= w_final;
               r_level_valid <= 1'b1;
               // Instant attack, one-step decay; level-1 is safe since new_level>=0.
               if (w_new_level >= r_level) begin
                  r_level <= w_new_level;
               end else begin
                  r_level <= r_level - 4'd1;
               end
            end else begin
               r_acc     <= w_final;
               r_win_cnt <= r_win_cnt + 16'd1;
            end
         end
      end
   end

   assign level       = r_level;
   assign level_valid = r_level_valid;
   assign peak        = r_peak;

endmodule
`default_nettype wire
